// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencing controller for the 5-stage MIPS pipeline. Produces the
// enable/flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers. It resolves load-use hazards, data-memory wait states,
// control redirects resolved in MEM, and a halt request with pipeline drain.
//
// Ports
//   clk, reset_n             clock / asynchronous active-low reset
//   id_rs_i, id_rt_i         source register fields of the instruction in ID
//   id_uses_rt_i             ID instruction reads rt as a source
//   id_ex_memread_i          ID/EX holds a load
//   id_ex_rt_i               destination rt of that load
//   ex_mem_redirect_i        taken branch/jump resolved in EX/MEM
//   mem_req_i, mem_ready_i   data-memory access pending / completing
//   halt_req_i               level request to halt fetch and drain
//   pc_en_o .. mem_wb_en_o   pipeline register enables and flushes
//                            (combinational, same-cycle hazard response)
//   halted_o                 pipeline fully drained and frozen
//   ctrl_state_o             0=RUN 1=MEM_WAIT 2=HALT_DRAIN 3=HALTED
//   stall_count_o            saturating load-use + memory-wait cycle count
//   flush_count_o            saturating redirect event count
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned DRAIN_CYCLES     = 3,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_ex_memread_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             ex_mem_redirect_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             halt_req_i,
    output logic             pc_en_o,
    output logic             pc_sel_redirect_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_en_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_en_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_en_o,
    output logic             halted_o,
    output logic [1:0]       ctrl_state_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned BUB_W = 3;
    localparam int unsigned DRN_W = 3;

    localparam logic [BUB_W-1:0] BUBBLE_RELOAD = BUB_W'(REDIRECT_BUBBLES);
    localparam logic [DRN_W-1:0] DRAIN_LAST    = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_HALT_DRAIN = 2'd2,
        ST_HALTED     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BUB_W-1:0]   bubble_left_q, bubble_left_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;

    logic               load_use;
    logic               mem_busy;
    logic               stall_evt;
    logic               flush_evt;

    // ID consumes the register an in-flight load has not yet produced; $zero never hazards
    assign load_use = id_ex_memread_i
                    & (id_ex_rt_i != REG_W'(0))
                    & ((id_ex_rt_i == id_rs_i) | (id_uses_rt_i & (id_ex_rt_i == id_rt_i)));

    // Once waiting, only mem_ready releases the freeze
    assign mem_busy = (state_q == ST_MEM_WAIT) ? ~mem_ready_i
                                               : (mem_req_i & ~mem_ready_i);

    // Next-state and pipeline control outputs
    always_comb begin
        pc_en_o           = 1'b1;
        pc_sel_redirect_o = 1'b0;
        if_id_en_o        = 1'b1;
        if_id_flush_o     = 1'b0;
        id_ex_en_o        = 1'b1;
        id_ex_flush_o     = 1'b0;
        ex_mem_en_o       = 1'b1;
        ex_mem_flush_o    = 1'b0;
        mem_wb_en_o       = 1'b1;
        state_d           = state_q;
        bubble_left_d     = bubble_left_q;
        drain_cnt_d       = drain_cnt_q;
        stall_evt         = 1'b0;
        flush_evt         = 1'b0;

        // Held in reset: present the no-hazard control values regardless of inputs
        if (reset_n) begin
            unique case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        pc_en_o     = 1'b0;
                        if_id_en_o  = 1'b0;
                        id_ex_en_o  = 1'b0;
                        ex_mem_en_o = 1'b0;
                        mem_wb_en_o = 1'b0;
                        stall_evt   = 1'b1;
                        state_d     = ST_MEM_WAIT;
                    end else if (ex_mem_redirect_i) begin
                        // The ID instruction is wrong-path, so any load-use hazard is moot
                        pc_sel_redirect_o = 1'b1;
                        if_id_flush_o     = 1'b1;
                        id_ex_flush_o     = 1'b1;
                        ex_mem_flush_o    = 1'b1;
                        bubble_left_d     = BUBBLE_RELOAD;
                        flush_evt         = 1'b1;
                        state_d           = ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                        if (bubble_left_q != BUB_W'(0)) begin
                            // I-fetch refill: PC advances but the fetched word is dropped
                            if_id_flush_o = 1'b1;
                            bubble_left_d = bubble_left_q - BUB_W'(1);
                        end else if (load_use) begin
                            pc_en_o       = 1'b0;
                            if_id_en_o    = 1'b0;
                            id_ex_flush_o = 1'b1;
                            stall_evt     = 1'b1;
                        end
                        if (halt_req_i) begin
                            state_d     = ST_HALT_DRAIN;
                            drain_cnt_d = DRN_W'(0);
                        end
                    end
                end

                ST_HALT_DRAIN: begin
                    pc_en_o    = 1'b0;
                    if_id_en_o = 1'b0;
                    if (mem_req_i & ~mem_ready_i) begin
                        // Freeze holds the drain count until memory completes
                        id_ex_en_o  = 1'b0;
                        ex_mem_en_o = 1'b0;
                        mem_wb_en_o = 1'b0;
                        stall_evt   = 1'b1;
                    end else begin
                        id_ex_flush_o = 1'b1;
                        if (ex_mem_redirect_i) begin
                            // Redirect is squashed: fetch stays frozen, only the wrong-path
                            // EX result is cleared and the event is still counted
                            ex_mem_flush_o = 1'b1;
                            flush_evt      = 1'b1;
                        end
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_d = ST_HALTED;
                        end else begin
                            drain_cnt_d = drain_cnt_q + DRN_W'(1);
                        end
                    end
                    if (!halt_req_i) begin
                        state_d = ST_RUN;
                    end
                end

                ST_HALTED: begin
                    pc_en_o     = 1'b0;
                    if_id_en_o  = 1'b0;
                    id_ex_en_o  = 1'b0;
                    ex_mem_en_o = 1'b0;
                    mem_wb_en_o = 1'b0;
                    if (!halt_req_i) begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Saturating performance counters: at most +1 per cycle
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_evt && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (flush_evt && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            bubble_left_q <= BUB_W'(0);
            drain_cnt_q   <= DRN_W'(0);
            stall_count_q <= CNT_W'(0);
            flush_count_q <= CNT_W'(0);
        end else begin
            state_q       <= state_d;
            bubble_left_q <= bubble_left_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign halted_o      = (state_q == ST_HALTED);
    assign ctrl_state_o  = state_q;
    assign stall_count_o = stall_count_q;
    assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=1, DRAIN_CYCLES=3,
// CNT_W=4). A behavioural model classifies each cycle into a pipeline action
// and derives the expected controls; every falling edge compares the DUT to the
// model, and hand-computed pins compare both the DUT and the model to literals.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int RB   = 1;
    localparam int DC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Control vector order: pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en,
    // id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en
    localparam logic [8:0] EN_FLOW   = 9'b1_0_1_0_1_0_1_0_1;
    localparam logic [8:0] EN_LU     = 9'b0_0_0_0_1_1_1_0_1;
    localparam logic [8:0] EN_FROZEN = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] EN_REDIR  = 9'b1_1_1_1_1_1_1_1_1;
    localparam logic [8:0] EN_BUBBLE = 9'b1_0_1_1_1_0_1_0_1;
    localparam logic [8:0] EN_DRAIN  = 9'b0_0_0_0_1_1_1_0_1;
    localparam logic [8:0] EN_DRSQ   = 9'b0_0_0_0_1_1_1_1_1;

    localparam int A_FLOW = 0;
    localparam int A_FRZ  = 1;
    localparam int A_RED  = 2;
    localparam int A_BUB  = 3;
    localparam int A_LU   = 4;

    typedef struct packed {
        logic [8:0]    ctl;
        logic          halted;
        logic [1:0]    state;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } obs_t;

    logic          clk;
    logic          reset_n;
    logic [4:0]    id_rs, id_rt, id_ex_rt;
    logic          id_uses_rt, id_ex_memread, ex_mem_redirect;
    logic          mem_req, mem_ready, halt_req;
    logic          pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, ex_mem_flush, mem_wb_en, halted;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_count, flush_count;

    pipe_hazard_ctrl #(
        .REDIRECT_BUBBLES(RB),
        .DRAIN_CYCLES    (DC),
        .CNT_W           (CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_rs_i          (id_rs),
        .id_rt_i          (id_rt),
        .id_uses_rt_i     (id_uses_rt),
        .id_ex_memread_i  (id_ex_memread),
        .id_ex_rt_i       (id_ex_rt),
        .ex_mem_redirect_i(ex_mem_redirect),
        .mem_req_i        (mem_req),
        .mem_ready_i      (mem_ready),
        .halt_req_i       (halt_req),
        .pc_en_o          (pc_en),
        .pc_sel_redirect_o(pc_sel_redirect),
        .if_id_en_o       (if_id_en),
        .if_id_flush_o    (if_id_flush),
        .id_ex_en_o       (id_ex_en),
        .id_ex_flush_o    (id_ex_flush),
        .ex_mem_en_o      (ex_mem_en),
        .ex_mem_flush_o   (ex_mem_flush),
        .mem_wb_en_o      (mem_wb_en),
        .halted_o         (halted),
        .ctrl_state_o     (ctrl_state),
        .stall_count_o    (stall_count),
        .flush_count_o    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: pipeline mode, pending bubbles, drain progress, counters
    int m_mode  = 0;
    int m_bub   = 0;
    int m_drain = 0;
    int m_stall = 0;
    int m_flush = 0;

    int    n_checks = 0;
    int    n_errors = 0;
    int    pin_seq  = 0;
    int    pin_seen = 0;
    obs_t  pin_v;
    string pin_name;

    function automatic obs_t mk(input logic [8:0] ctl, input logic h, input int st,
                                input int s, input int f);
        obs_t o;
        o = {ctl, h, 2'(st), CW'(s), CW'(f)};
        return o;
    endfunction

    // Expected outputs for the current cycle plus the model's next state
    function automatic obs_t model_out(output int nmode, output int nbub, output int ndrain,
                                       output int nstall, output int nflush);
        obs_t       o;
        logic [8:0] ctl;
        bit         lu, busy, sev, fev;
        int         act;
        nmode  = m_mode;
        nbub   = m_bub;
        ndrain = m_drain;
        sev    = 1'b0;
        fev    = 1'b0;
        ctl    = EN_FLOW;
        act    = A_FLOW;
        lu = id_ex_memread && (id_ex_rt != 5'd0) &&
             ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
        if (!reset_n) begin
            nmode = 0; nbub = 0; ndrain = 0; nstall = 0; nflush = 0;
            o = mk(EN_FLOW, 1'b0, 0, 0, 0);
            return o;
        end
        if (m_mode == 3) begin
            ctl = EN_FROZEN;
            if (!halt_req) nmode = 0;
        end else if (m_mode == 2) begin
            if (mem_req && !mem_ready) begin
                ctl = EN_FROZEN;
                sev = 1'b1;
            end else begin
                ctl = ex_mem_redirect ? EN_DRSQ : EN_DRAIN;
                fev = ex_mem_redirect;
                ndrain = m_drain + 1;
                if (ndrain == DC) nmode = 3;
            end
            if (!halt_req) nmode = 0;
        end else begin
            busy = (m_mode == 1) ? !mem_ready : (mem_req && !mem_ready);
            if (busy)                 act = A_FRZ;
            else if (ex_mem_redirect) act = A_RED;
            else if (m_bub > 0)       act = A_BUB;
            else if (lu)              act = A_LU;
            case (act)
                A_FRZ: begin ctl = EN_FROZEN; sev = 1'b1; nmode = 1; end
                A_RED: begin ctl = EN_REDIR; fev = 1'b1; nbub = RB; nmode = 0; end
                A_BUB: begin ctl = EN_BUBBLE; nbub = m_bub - 1; end
                A_LU:  begin ctl = EN_LU; sev = 1'b1; end
                default: ;
            endcase
            if (act != A_FRZ && act != A_RED) begin
                nmode  = halt_req ? 2 : 0;
                ndrain = 0;
            end
        end
        nstall = (sev && m_stall < CMAX) ? m_stall + 1 : m_stall;
        nflush = (fev && m_flush < CMAX) ? m_flush + 1 : m_flush;
        o = mk(ctl, (m_mode == 3), m_mode, m_stall, m_flush);
        return o;
    endfunction

    // Model state advance on the active edge, async reset
    initial forever begin
        obs_t unused_o;
        int   a, b, c, d, e;
        @(posedge clk or negedge reset_n);
        unused_o = model_out(a, b, c, d, e);
        m_mode  = a;
        m_bub   = b;
        m_drain = c;
        m_stall = d;
        m_flush = e;
    end

    // Compare on the falling edge, away from input changes and the active edge
    initial forever begin
        obs_t exp_o, act_o;
        int   a, b, c, d, e;
        @(negedge clk);
        exp_o = model_out(a, b, c, d, e);
        act_o = {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, ex_mem_flush, mem_wb_en, halted, ctrl_state, stall_count, flush_count};
        n_checks++;
        if (act_o !== exp_o) begin
            n_errors++;
            $display("FAIL model t=%0t got=%h expected=%h", $time, act_o, exp_o);
        end
        if (pin_seq != pin_seen) begin
            pin_seen = pin_seq;
            n_checks++;
            if (act_o !== pin_v) begin
                n_errors++;
                $display("FAIL pin_%s got=%h expected=%h", pin_name, act_o, pin_v);
            end
            n_checks++;
            if (exp_o !== pin_v) begin
                n_errors++;
                $display("FAIL pinmodel_%s model=%h expected=%h", pin_name, exp_o, pin_v);
            end
        end
    end

    task automatic drv(input logic ld, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic red,
                       input logic mq, input logic mr, input logic h);
        id_ex_memread   = ld;
        id_ex_rt        = ert;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = uses;
        ex_mem_redirect = red;
        mem_req         = mq;
        mem_ready       = mr;
        halt_req        = h;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_pin(input string nm, input obs_t v);
        pin_name = nm;
        pin_v    = v;
        pin_seq++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input obs_t v);
        set_pin(nm, v);
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        step("reset_gate", mk(EN_FLOW, 0, 0, 0, 0));
        reset_n = 1'b1;
        idle();
        step("idle", mk(EN_FLOW, 0, 0, 0, 0));

        // Load-use
        drv(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu_rs", mk(EN_LU, 0, 0, 0, 0));
        idle();
        step("lu_after", mk(EN_FLOW, 0, 0, 1, 0));
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu_zero", mk(EN_FLOW, 0, 0, 1, 0));
        drv(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu_rt_unused", mk(EN_FLOW, 0, 0, 1, 0));
        drv(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu_rt_used", mk(EN_LU, 0, 0, 1, 0));
        idle();
        step("lu_done", mk(EN_FLOW, 0, 0, 2, 0));

        // Memory wait: three not-ready cycles then ready
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mw_1", mk(EN_FROZEN, 0, 0, 2, 0));
        step("mw_2", mk(EN_FROZEN, 0, 1, 3, 0));
        step("mw_3", mk(EN_FROZEN, 0, 1, 4, 0));
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mw_ready", mk(EN_FLOW, 0, 1, 5, 0));
        idle();
        step("mw_run", mk(EN_FLOW, 0, 0, 5, 0));

        // Redirect with one refill bubble
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("redir", mk(EN_REDIR, 0, 0, 5, 0));
        idle();
        step("redir_bubble", mk(EN_BUBBLE, 0, 0, 5, 1));
        step("redir_done", mk(EN_FLOW, 0, 0, 5, 1));

        // Redirect together with load-use: redirect wins, bubble beats load-use
        drv(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("redir_lu", mk(EN_REDIR, 0, 0, 5, 1));
        drv(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("bubble_lu", mk(EN_BUBBLE, 0, 0, 5, 2));
        idle();
        step("redir_lu_done", mk(EN_FLOW, 0, 0, 5, 2));

        // Redirect while memory not ready: freeze first, redirect on the ready cycle
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("redir_frz_1", mk(EN_FROZEN, 0, 0, 5, 2));
        step("redir_frz_2", mk(EN_FROZEN, 0, 1, 6, 2));
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("redir_on_ready", mk(EN_REDIR, 0, 1, 7, 2));
        idle();
        step("redir_rdy_bubble", mk(EN_BUBBLE, 0, 0, 7, 3));
        step("redir_rdy_done", mk(EN_FLOW, 0, 0, 7, 3));

        // Halt with a 2-cycle memory wait in the middle of the drain
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("halt_req", mk(EN_FLOW, 0, 0, 7, 3));
        step("drain_0", mk(EN_DRAIN, 0, 2, 7, 3));
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("drain_frz_1", mk(EN_FROZEN, 0, 2, 7, 3));
        step("drain_frz_2", mk(EN_FROZEN, 0, 2, 8, 3));
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("drain_1", mk(EN_DRAIN, 0, 2, 9, 3));
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("drain_2", mk(EN_DRAIN, 0, 2, 9, 3));
        step("halted_1", mk(EN_FROZEN, 1, 3, 9, 3));
        step("halted_2", mk(EN_FROZEN, 1, 3, 9, 3));
        idle();
        step("halted_release", mk(EN_FROZEN, 1, 3, 9, 3));
        step("halt_resumed", mk(EN_FLOW, 0, 0, 9, 3));

        // Halt dropped mid-drain
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("abort_req", mk(EN_FLOW, 0, 0, 9, 3));
        step("abort_drain", mk(EN_DRAIN, 0, 2, 9, 3));
        idle();
        step("abort_drop", mk(EN_DRAIN, 0, 2, 9, 3));
        step("abort_run", mk(EN_FLOW, 0, 0, 9, 3));

        // Redirect squashed into the drain is still counted
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("sq_req", mk(EN_FLOW, 0, 0, 9, 3));
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("sq_counted", mk(EN_DRAIN, 0, 2, 9, 4));
        idle();
        step("sq_drop", mk(EN_DRAIN, 0, 2, 9, 4));
        step("sq_run", mk(EN_FLOW, 0, 0, 9, 4));

        // Stall counter saturation
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("sat_ready", mk(EN_FLOW, 0, 1, CMAX, 4));
        drv(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("sat_lu", mk(EN_LU, 0, 0, CMAX, 4));
        idle();
        step("sat_hold", mk(EN_FLOW, 0, 0, CMAX, 4));

        // Reset in the middle of a memory wait
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rst_mw_1", mk(EN_FROZEN, 0, 0, CMAX, 4));
        step("rst_mw_2", mk(EN_FROZEN, 0, 1, CMAX, 4));
        set_pin("reset_mid", mk(EN_FLOW, 0, 0, 0, 0));
        #2 reset_n = 1'b0;
        tick();
        idle();
        reset_n = 1'b1;
        step("post_reset", mk(EN_FLOW, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
